// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - cursor controller: press arbitration, wrap-around moves, auto-repeat
module cursor_ctrl #(
  parameter int GRID         = 9,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_state,
  input  logic [4:0] i_ondn,
  input  logic       i_enable,
  output logic [3:0] o_row,
  output logic [3:0] o_col,
  output logic       o_move,
  output logic [1:0] o_dir,
  output logic       o_select
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic [3:0]    POS_LAST   = 4'(GRID - 1);
  localparam logic [3:0]    POS_MID    = 4'(GRID / 2);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [3:0]    row_q, row_d, col_q, col_d;
  logic [1:0]    dir_q, dir_d, held_q, held_d, state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          move_q, move_d, sel_q, sel_d;
  logic          do_move;
  logic [1:0]    mv_dir;
  logic [1:0]    press_dir;
  logic          press_any;

  function automatic logic [3:0] pos_dec(input logic [3:0] v);
    return (v == 4'd0) ? POS_LAST : v - 4'd1;
  endfunction

  function automatic logic [3:0] pos_inc(input logic [3:0] v);
    return (v == POS_LAST) ? 4'd0 : v + 4'd1;
  endfunction

  // Direction priority among the four moves: up > down > left > right.
  always_comb begin
    press_any = |i_ondn[3:0];
    if (i_ondn[0])      press_dir = 2'd0;
    else if (i_ondn[1]) press_dir = 2'd1;
    else if (i_ondn[2]) press_dir = 2'd2;
    else                press_dir = 2'd3;
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    held_d  = held_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    move_d  = 1'b0;
    sel_d   = 1'b0;
    do_move = 1'b0;
    mv_dir  = held_q;

    if (!i_enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (i_ondn[4]) begin
      sel_d = 1'b1;
    end else if (press_any) begin
      do_move = 1'b1;
      mv_dir  = press_dir;
      held_d  = press_dir;
      cnt_d   = '0;
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD, ST_REPEAT: begin
          if (!i_state[held_q]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == ST_HOLD) ? DELAY_LAST : RATE_LAST)) begin
            do_move = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (do_move) begin
      move_d = 1'b1;
      dir_d  = mv_dir;
      case (mv_dir)
        2'd0:    row_d = pos_dec(row_q);
        2'd1:    row_d = pos_inc(row_q);
        2'd2:    col_d = pos_dec(col_q);
        default: col_d = pos_inc(col_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= POS_MID;
      col_q   <= POS_MID;
      dir_q   <= 2'd0;
      held_q  <= 2'd0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      move_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      held_q  <= held_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      move_q  <= move_d;
      sel_q   <= sel_d;
    end
  end

  assign o_row    = row_q;
  assign o_col    = col_q;
  assign o_move   = move_q;
  assign o_dir    = dir_q;
  assign o_select = sel_q;

endmodule
